dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data RAM between two requesters.
//  - Port 0: the CPU MEM stage (lw/sw).
//  - Port 1: the debug/DMA loader.
//  Sequences each access over a fixed RAM latency and returns read data with a one-cycle ack.
//  Drives cpu_stall so the core holds while its access is pending.
// PARAMETERS
//  AW       32  address width (byte address)
//  DW       32  data width
//  LATENCY  1   cycles from mem_ce assertion to valid mem_rdata; legal range 1..15
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, synchronous, active-high
//  req_i      in   2   per-port request; held high until matching ack_o
//  we_i       in   2   per-port write enable (1 = store, 0 = load)
//  addr0_i    in   AW  port 0 byte address
//  addr1_i    in   AW  port 1 byte address
//  wdata0_i   in   DW  port 0 store data
//  wdata1_i   in   DW  port 1 store data
//  ack_o      out  2   per-port one-cycle completion pulse
//  rdata_o    out  DW  load data; valid only while an ack_o bit is high
//  cpu_stall  out  1   req_i[0] & ~ack_o[0]
//  busy_o     out  1   state != IDLE
//  mem_ce     out  1   RAM chip enable
//  mem_we     out  1   RAM write enable
//  mem_addr   out  AW  RAM address; bits [1:0] forced to 2'b00
//  mem_wdata  out  DW  RAM write data
//  mem_rdata  in   DW  RAM read data
// BEHAVIOUR
//  - FSM states: IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered except cpu_stall and busy_o.
//  - IDLE: if any req_i bit is set, pick a winner and latch its we, addr and wdata. Load cnt = LATENCY-1, go to ACCESS.
//  - ACCESS:
//    - mem_ce = 1, with mem_we, mem_addr and mem_wdata driven from the latched values and held stable.
//    - When cnt == 0: capture mem_rdata into rdata_o, drop mem_ce/mem_we, go to RESP. Otherwise decrement cnt.
//  - RESP: ack_o[winner] = 1 for exactly one cycle, then go to IDLE. rdata_o holds its value until the next capture.
//  - Timing: a request seen in IDLE at edge t gives mem_ce high for LATENCY cycles, then ack on the cycle after.
//    Load-to-ack latency is LATENCY+2 edges. Stores use identical timing; rdata_o is don't-care on stores.
//  - Requests are never pre-empted. A req change during ACCESS or RESP is ignored; the latched transaction completes and still acks.
//  - Back-to-back: every transaction passes through IDLE for at least one cycle. Peak throughput is 1 access per LATENCY+2 cycles.
//  - Simultaneous requests: arbitrated per CONFIGURATION. The loser stays pending and is served next.
//  - Reset values: state = IDLE; ack_o, mem_ce, mem_we = 0; mem_addr, mem_wdata, rdata_o = 0; cnt = 0; last_grant = 1.
//  - Reset mid-access: the state aborts to IDLE at that edge and no ack is issued. The requester re-issues after reset.
// CONFIGURATION
//  DMEM_ARB_RR_EN undefined:
//  - Fixed priority: port 0 (CPU) always wins a tie.
//  DMEM_ARB_RR_EN defined:
//  - Round-robin: a tie goes to the port NOT equal to last_grant.
//  - last_grant updates on each grant in IDLE.
//  - A single requester always wins regardless of last_grant.
// STRUCTURE
//  - dmem_arb_pkg: state encoding (IDLE/ACCESS/RESP), port index constants P_CPU = 0 and P_DBG = 1, and the cnt width (4).
//  - Sub-module dmem_arb_picker: combinational winner select from req_i and last_grant.
//    It holds the DMEM_ARB_RR_EN conditional so the FSM is unchanged between builds.
// TESTING
//  1. LATENCY=1; port 0 load from 0x0000_0010, RAM returns 0xDEAD_BEEF.
//     -> mem_ce is high for 1 cycle; ack_o = 2'b01 on the 3rd edge; rdata_o = 0xDEAD_BEEF.
//     -> cpu_stall is high until that ack.
//  2. Port 0 store of 0x1234_5678 to 0x0000_0023.
//     -> mem_we = 1; mem_addr = 0x0000_0020; mem_wdata = 0x1234_5678; one ack on port 0.
//  3. Both ports request in the same cycle, fixed build.
//     -> Port 0 is acked first, port 1 is acked LATENCY+2 cycles later.
//     -> With DMEM_ARB_RR_EN and last_grant = 0, port 1 is served first.
//  4. LATENCY=3; a port 1 load.
//     -> mem_ce is high for exactly 3 cycles; rdata_o is sampled on the last; ack follows.
//     -> A port 0 req raised mid-access is granted only after the return to IDLE.
//  5. rst asserted during ACCESS.
//     -> At the next edge mem_ce = 0, state = IDLE, no ack pulse.
//     -> After reset the re-issued request completes normally.
//  6. Port 1 drops req_i during ACCESS.
//     -> The transaction completes; ack_o[1] still pulses once; the FSM returns to IDLE cleanly.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices
// and the latency counter width.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arb_picker.sv
// Combinational winner select between the CPU and debug ports.
// Build option DMEM_ARB_RR_EN switches ties from fixed CPU priority to round-robin.
module dmem_arb_picker
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       winner_o
);

`ifdef DMEM_ARB_RR_EN
  // A tie goes to whichever port was not granted last; a lone requester always wins.
  always_comb begin
    winner_o = P_CPU;
    if (req_i == 2'b11) begin
      winner_o = ~last_grant_i;
    end else if (req_i[P_DBG]) begin
      winner_o = P_DBG;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    winner_o = P_CPU;
    if (!req_i[P_CPU] && req_i[P_DBG]) begin
      winner_o = P_DBG;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM (CPU MEM stage + debug/DMA loader).
// Tie policy comes from dmem_arb_picker; define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_i,
  input  logic [1:0]    we_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic [1:0]    ack_o,
  output logic [DW-1:0] rdata_o,
  output logic          cpu_stall,
  output logic          busy_o,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             winner_q, winner_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       ack_q, ack_d;
  logic             ce_q, ce_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             pick;

  dmem_arb_picker u_picker (
    .req_i        (req_i),
    .last_grant_i (last_grant_q),
    .winner_o     (pick)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    ack_d        = 2'b00;
    ce_d         = ce_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          winner_d     = pick;
          last_grant_d = pick;
          we_d         = we_i[pick];
          addr_d       = {(pick ? addr1_i[AW-1:2] : addr0_i[AW-1:2]), 2'b00};
          wdata_d      = pick ? wdata1_i : wdata0_i;
          ce_d         = 1'b1;
          cnt_d        = CNT_INIT;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // RAM data is valid in the last enabled cycle; capture it and raise the ack.
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          ce_d    = 1'b0;
          we_d    = 1'b0;
          ack_d   = winner_q ? 2'b10 : 2'b01;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      winner_q     <= P_CPU;
      last_grant_q <= 1'b1;
      ack_q        <= 2'b00;
      ce_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      ce_q         <= ce_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign mem_ce    = ce_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy_o    = (state_q != S_IDLE);
  assign cpu_stall = req_i[P_CPU] & ~ack_q[P_CPU];

endmodule
